int_sequencer: RTL and testbench

- Parametrised interrupt/reset sequencer for the cpu6502 core. Replaces the fixed reset_f/vector_lo bootstrap logic.
- Latches reset, edge-triggered NMI and NUM_IRQ maskable level IRQ sources, and arbitrates them at instruction boundaries. Tells the core to inject a BRK sequence.
- Supplies the vector low/high bytes and the pushed B bit.
- Handles NMI hijack of in-flight BRK/IRQ sequences and an optional per-source vectored IRQ mode.

---
 rtl/int_sequencer.sv | 165 ++++++++++++++++
 tb/tb_int_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer for the cpu6502 core: latches RST/NMI/IRQ requests,
// arbitrates at opcode fetch, and supplies the vector and pushed B bit for the BRK sequence.
module int_sequencer #(
  parameter int         NUM_IRQ      = 4,
  parameter int         VECTORED     = 0,
  parameter logic [7:0] VEC_HI       = 8'hFF,
  parameter logic [7:0] RST_VEC_LO   = 8'hFC,
  parameter logic [7:0] NMI_VEC_LO   = 8'hFA,
  parameter logic [7:0] IRQ_VEC_LO   = 8'hFE,
  parameter logic [7:0] VEC_TABLE_LO = 8'hE0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               nmi,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               i_flag,
  input  logic               fetch,
  input  logic               brk_op,
  input  logic               vec_req,
  output logic               take_int,
  output logic [7:0]         vec_lo,
  output logic [7:0]         vec_hi,
  output logic               b_flag,
  output logic               int_ack,
  output logic [3:0]         ack_src
);

  typedef enum logic {S_IDLE, S_SEQ} state_t;
  typedef enum logic [1:0] {K_BRK, K_RST, K_NMI, K_IRQ} kind_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d, kind_eff;
  logic [2:0] idx_q, idx_d, win_idx;
  logic       rst_pend_q, rst_pend_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_last_q;
  logic       b_flag_q, b_flag_d;
  logic       int_ack_q, int_ack_d;
  logic [3:0] ack_src_q, ack_src_d;
  logic [7:0] vec_lo_q, vec_lo_d, vec_sel;
  logic [NUM_IRQ-1:0] irq_req;
  logic       irq_act, nmi_set, any_req, commit;

  assign irq_req = irq_src & irq_mask;
  assign irq_act = (|irq_req) & ~i_flag;
  assign nmi_set = nmi & ~nmi_last_q;
  assign any_req = rst_pend_q | nmi_pend_q | irq_act;
  assign commit  = (state_q == S_SEQ) && vec_req;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_req[i]) win_idx = 3'(i);
  end

  // A pending NMI takes over an in-flight BRK/IRQ sequence until the vector is committed.
  always_comb begin
    kind_eff = kind_q;
    if (state_q == S_SEQ && (kind_q == K_BRK || kind_q == K_IRQ) && nmi_pend_q)
      kind_eff = K_NMI;
  end

  always_comb begin
    vec_sel = IRQ_VEC_LO;
    case (kind_eff)
      K_RST:   vec_sel = RST_VEC_LO;
      K_NMI:   vec_sel = NMI_VEC_LO;
      K_BRK:   vec_sel = IRQ_VEC_LO;
      K_IRQ:   vec_sel = (VECTORED != 0) ? 8'(VEC_TABLE_LO + {4'b0, idx_q, 1'b0})
                                         : IRQ_VEC_LO;
      default: vec_sel = IRQ_VEC_LO;
    endcase
  end

  assign take_int = (state_q == S_IDLE) && fetch && any_req;
  assign vec_lo   = (state_q == S_SEQ) ? vec_sel : vec_lo_q;
  assign vec_hi   = VEC_HI;
  assign b_flag   = b_flag_q;
  assign int_ack  = int_ack_q;
  assign ack_src  = ack_src_q;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    idx_d      = idx_q;
    rst_pend_d = rst_pend_q;
    nmi_pend_d = nmi_pend_q;
    b_flag_d   = b_flag_q;
    int_ack_d  = 1'b0;
    ack_src_d  = ack_src_q;
    vec_lo_d   = vec_lo_q;
    case (state_q)
      S_IDLE: begin
        if (fetch) begin
          if (any_req) begin
            state_d  = S_SEQ;
            b_flag_d = 1'b0;
            if (rst_pend_q)      kind_d = K_RST;
            else if (nmi_pend_q) kind_d = K_NMI;
            else begin
              kind_d = K_IRQ;
              idx_d  = win_idx;
            end
          end
        end else if (brk_op) begin
          state_d  = S_SEQ;
          kind_d   = K_BRK;
          b_flag_d = 1'b1;
        end
      end
      S_SEQ: begin
        kind_d   = kind_eff;
        vec_lo_d = vec_sel;
        if (vec_req) begin
          state_d   = S_IDLE;
          int_ack_d = 1'b1;
          case (kind_eff)
            K_BRK:   ack_src_d = 4'd0;
            K_RST:   ack_src_d = 4'd1;
            K_NMI:   ack_src_d = 4'd2;
            default: ack_src_d = {1'b1, idx_q};
          endcase
          if (kind_eff == K_RST) rst_pend_d = 1'b0;
          if (kind_eff == K_NMI) nmi_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A fresh edge always wins over a same-cycle commit clear.
    if (nmi_set) nmi_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      kind_q     <= K_RST;
      idx_q      <= 3'd0;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_last_q <= 1'b0;
      b_flag_q   <= 1'b0;
      int_ack_q  <= 1'b0;
      ack_src_q  <= 4'd1;
      vec_lo_q   <= RST_VEC_LO;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      idx_q      <= idx_d;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_last_q <= nmi;
      b_flag_q   <= b_flag_d;
      int_ack_q  <= int_ack_d;
      ack_src_q  <= ack_src_d;
      vec_lo_q   <= vec_lo_d;
    end
  end

  // Unused upper commit-path check keeps commit meaningful for readers of waveforms.
  logic unused_commit;
  assign unused_commit = commit;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench: one vectored and one non-vectored sequencer driven by the same stimulus.
module tb_int_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, nmi, i_flag, fetch, brk_op, vec_req;
  logic [3:0] irq_src, irq_mask;
  logic       take_int0, b_flag0, int_ack0, take_int1, b_flag1, int_ack1;
  logic [7:0] vec_lo0, vec_hi0, vec_lo1, vec_hi1;
  logic [3:0] ack_src0, ack_src1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_sequencer #(.NUM_IRQ(4), .VECTORED(0)) u0 (
    .clk(clk), .reset_n(reset_n), .nmi(nmi), .irq_src(irq_src), .irq_mask(irq_mask),
    .i_flag(i_flag), .fetch(fetch), .brk_op(brk_op), .vec_req(vec_req),
    .take_int(take_int0), .vec_lo(vec_lo0), .vec_hi(vec_hi0), .b_flag(b_flag0),
    .int_ack(int_ack0), .ack_src(ack_src0));

  int_sequencer #(.NUM_IRQ(4), .VECTORED(1)) u1 (
    .clk(clk), .reset_n(reset_n), .nmi(nmi), .irq_src(irq_src), .irq_mask(irq_mask),
    .i_flag(i_flag), .fetch(fetch), .brk_op(brk_op), .vec_req(vec_req),
    .take_int(take_int1), .vec_lo(vec_lo1), .vec_hi(vec_hi1), .b_flag(b_flag1),
    .int_ack(int_ack1), .ack_src(ack_src1));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; nmi = 1'b0; i_flag = 1'b0; fetch = 1'b0; brk_op = 1'b0;
    vec_req = 1'b0; irq_src = 4'h0; irq_mask = 4'hF;
    #12;
    chk("rst_take", take_int1, 0);
    chk("rst_ack", int_ack1, 0);
    chk("rst_src", ack_src1, 1);
    chk("rst_b", b_flag1, 0);
    chk("rst_vlo", vec_lo1, 8'hFC);
    chk("rst_vhi", vec_hi1, 8'hFF);
    @(negedge clk) reset_n = 1'b1;
    step();

    // reset sequence
    fetch = 1'b1; #1 chk("t1_take", take_int1, 1);
    step(); fetch = 1'b0; vec_req = 1'b1;
    #1 chk("t1_vlo", vec_lo1, 8'hFC);
    step(); vec_req = 1'b0;
    chk("t1_ack", int_ack1, 1);
    chk("t1_src", ack_src1, 1);
    chk("t1_b", b_flag1, 0);
    fetch = 1'b1; #1 chk("t1_take2", take_int1, 0);
    step(); fetch = 1'b0;
    chk("t1_ack_pulse", int_ack1, 0);

    // IRQ: winner is source 1; deassert after entry, latched index still used
    irq_src = 4'b0110;
    fetch = 1'b1; #1 chk("t2_take", take_int1, 1);
    step(); fetch = 1'b0; irq_src = 4'h0; vec_req = 1'b1;
    #1 chk("t2_vlo_vec", vec_lo1, 8'hE2);
    chk("t2_vlo_flat", vec_lo0, 8'hFE);
    step(); vec_req = 1'b0;
    chk("t2_ack", int_ack1, 1);
    chk("t2_src_vec", ack_src1, 9);
    chk("t2_src_flat", ack_src0, 9);

    // i_flag masks IRQ; NMI edge while held high fires once
    irq_src = 4'b0110; i_flag = 1'b1;
    fetch = 1'b1; #1 chk("t3_take_masked", take_int1, 0);
    step(); fetch = 1'b0; nmi = 1'b1;
    step();
    fetch = 1'b1; #1 chk("t3_take_nmi", take_int1, 1);
    step(); fetch = 1'b0; vec_req = 1'b1;
    #1 chk("t3_vlo", vec_lo1, 8'hFA);
    step(); vec_req = 1'b0;
    chk("t3_src", ack_src1, 2);
    fetch = 1'b1; #1 chk("t3_take_held", take_int1, 0);
    step(); fetch = 1'b0; nmi = 1'b0; irq_src = 4'h0;

    // BRK hijacked by NMI
    brk_op = 1'b1; step(); brk_op = 1'b0;
    chk("t4_b_brk", b_flag1, 1);
    step(); nmi = 1'b1;
    step(); nmi = 1'b0; vec_req = 1'b1;
    #1 chk("t4_vlo", vec_lo1, 8'hFA);
    chk("t4_b", b_flag1, 1);
    step(); vec_req = 1'b0;
    chk("t4_ack", int_ack1, 1);
    chk("t4_src", ack_src1, 2);
    chk("t4_b_hold", b_flag1, 1);
    fetch = 1'b1; #1 chk("t4_nmi_clr", take_int1, 0);
    step(); fetch = 1'b0;

    // NMI edge in the IRQ vec_req cycle re-pends
    i_flag = 1'b0; irq_src = 4'b0001;
    fetch = 1'b1; #1 chk("t5_take", take_int0, 1);
    step(); fetch = 1'b0; irq_src = 4'h0; vec_req = 1'b1; nmi = 1'b1;
    #1 chk("t5_vlo_flat", vec_lo0, 8'hFE);
    chk("t5_vlo_vec", vec_lo1, 8'hE0);
    step(); vec_req = 1'b0; nmi = 1'b0;
    chk("t5_src", ack_src0, 8);
    fetch = 1'b1; #1 chk("t5_take_nmi", take_int0, 1);
    step(); fetch = 1'b0; vec_req = 1'b1;
    #1 chk("t5_vlo_nmi", vec_lo0, 8'hFA);
    step(); vec_req = 1'b0;
    chk("t5_src_nmi", ack_src0, 2);
    step();
    chk("t5_ack_pulse", int_ack0, 0);
    chk("t5_vlo_hold", vec_lo0, 8'hFA);
    vec_req = 1'b1; step(); vec_req = 1'b0;
    chk("t5_idle_vreq", int_ack0, 0);

    // reset mid-SEQ
    irq_src = 4'b0100;
    fetch = 1'b1; step(); fetch = 1'b0; irq_src = 4'h0;
    step();
    reset_n = 1'b0;
    #1 chk("t6_take", take_int1, 0);
    chk("t6_ack", int_ack1, 0);
    chk("t6_src", ack_src1, 1);
    chk("t6_b", b_flag1, 0);
    chk("t6_vlo", vec_lo1, 8'hFC);
    @(negedge clk) reset_n = 1'b1;
    vec_req = 1'b1; step(); vec_req = 1'b0;
    chk("t6_no_ack", int_ack1, 0);
    fetch = 1'b1; #1 chk("t6_take_rst", take_int1, 1);
    step(); fetch = 1'b0; vec_req = 1'b1;
    #1 chk("t6_vlo_rst", vec_lo1, 8'hFC);
    step(); vec_req = 1'b0;
    chk("t6_ack_rst", int_ack1, 1);
    chk("t6_src_rst", ack_src1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
